// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width helpers and wrap-bit pointer arithmetic.
// Pointers are passed zero-extended to ptr_t; ptr_w is the real pointer width including the wrap bit.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int level_w(input int depth_width);
    return depth_width + 1;
  endfunction

  function automatic ptr_t ptr_mask(input int ptr_w);
    return (ptr_t'(1) << ptr_w) - ptr_t'(1);
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p, input int ptr_w);
    return (p + ptr_t'(1)) & ptr_mask(ptr_w);
  endfunction

  // Full: address bits match, wrap bit differs.
  function automatic logic ptr_full(input ptr_t wr, input ptr_t rd, input int ptr_w);
    return ((wr ^ rd) & ptr_mask(ptr_w)) == (ptr_t'(1) << (ptr_w - 1));
  endfunction

  function automatic logic ptr_empty(input ptr_t wr, input ptr_t rd, input int ptr_w);
    return ((wr ^ rd) & ptr_mask(ptr_w)) == '0;
  endfunction

endpackage

// File: rtl/fifo_fwft_outstage.sv
// Head-word stage: read handshake, next-to-present RAM address and head valid flag.
// The RAM re-reads the head address every idle cycle, so its registered dout holds the head word.
module fifo_fwft_outstage
  import fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   clr_i,
  input  logic [DEPTH_WIDTH:0]   rd_ptr_q_i,
  input  logic [DEPTH_WIDTH:0]   wr_ptr_d_i,
  input  logic                   rd_ready_i,
  input  logic [DATA_WIDTH-1:0]  ram_dout_i,
  output logic                   rd_en_o,
  output logic [DEPTH_WIDTH:0]   rd_ptr_d_o,
  output logic [DEPTH_WIDTH-1:0] ram_raddr_o,
  output logic                   rd_valid_o,
  output logic [DATA_WIDTH-1:0]  rd_data_o
);

  localparam int PTR_W = DEPTH_WIDTH + 1;

  logic             valid_q;
  logic             valid_d;
  logic [PTR_W-1:0] rd_ptr_inc;

  assign rd_ptr_inc  = PTR_W'(ptr_inc(ptr_t'(rd_ptr_q_i), PTR_W));
  assign rd_en_o     = valid_q & rd_ready_i & ~clr_i;
  assign rd_ptr_d_o  = rd_en_o ? rd_ptr_inc : rd_ptr_q_i;
  // Prefetch: fetch the word that will be the head after this edge.
  assign ram_raddr_o = rd_ptr_d_o[DEPTH_WIDTH-1:0];

  assign valid_d = ~clr_i & ~ptr_empty(ptr_t'(wr_ptr_d_i), ptr_t'(rd_ptr_d_o), PTR_W);

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
  end

  assign rd_valid_o = valid_q;
  assign rd_data_o  = ram_dout_i;

endmodule

// File: rtl/simple_dpram_sclk.sv
// Single-clock simple dual-port RAM with registered read and optional write-to-read bypass.
module simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:2**ADDR_WIDTH-1];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= din_i;
  end

  if (ENABLE_BYPASS != 0) begin : g_bypass
    always_ff @(posedge clk) begin
      if (re_i) dout_q <= (we_i && (waddr_i == raddr_i)) ? din_i : mem_q[raddr_i];
    end
  end else begin : g_no_bypass
    always_ff @(posedge clk) begin
      if (re_i) dout_q <= mem_q[raddr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO, 2**DEPTH_WIDTH entries, valid/ready on both sides.
// Define FIFO_FLUSH_EN to add flush_i, which empties the FIFO like rst.
module fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int AF_THRESH   = 2**DEPTH_WIDTH - 1,
  parameter int AE_THRESH   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FIFO_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DEPTH_WIDTH:0]  level_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int PTR_W = DEPTH_WIDTH + 1;
  localparam int LVL_W = level_w(DEPTH_WIDTH);
  localparam int CAP   = 2**DEPTH_WIDTH;

  if (DEPTH_WIDTH < 1 || DATA_WIDTH < 1 || AF_THRESH > CAP || AE_THRESH >= CAP) begin : g_param_check
    $error("fifo_fwft: illegal DEPTH_WIDTH/DATA_WIDTH/AF_THRESH/AE_THRESH");
  end

  logic clr;
`ifdef FIFO_FLUSH_EN
  assign clr = rst | flush_i;
`else
  assign clr = rst;
`endif

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   wr_en, rd_en;
  logic [DEPTH_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0]  ram_dout;

  // Readiness comes from the registered level only: no same-cycle pass-through when full.
  assign wr_ready_o = ~rst & (level_q != LVL_W'(CAP));
  assign wr_en      = wr_valid_i & wr_ready_o & ~clr;
  assign wr_ptr_d   = wr_en ? PTR_W'(ptr_inc(ptr_t'(wr_ptr_q), PTR_W)) : wr_ptr_q;

  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign level_o        = level_q;
  assign almost_full_o  = (level_q >= LVL_W'(AF_THRESH));
  assign almost_empty_o = (level_q <= LVL_W'(AE_THRESH));

  // Bypass covers a write landing on the address being prefetched (empty, or level 1 with a read).
  simple_dpram_sclk #(
    .ADDR_WIDTH   (DEPTH_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .ENABLE_BYPASS(1)
  ) u_ram (
    .clk    (clk),
    .raddr_i(ram_raddr),
    .re_i   (1'b1),
    .waddr_i(wr_ptr_q[DEPTH_WIDTH-1:0]),
    .we_i   (wr_en),
    .din_i  (wr_data_i),
    .dout_o (ram_dout)
  );

  fifo_fwft_outstage #(
    .DEPTH_WIDTH(DEPTH_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outstage (
    .clk        (clk),
    .clr_i      (clr),
    .rd_ptr_q_i (rd_ptr_q),
    .wr_ptr_d_i (wr_ptr_d),
    .rd_ready_i (rd_ready_i),
    .ram_dout_i (ram_dout),
    .rd_en_o    (rd_en),
    .rd_ptr_d_o (rd_ptr_d),
    .ram_raddr_o(ram_raddr),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o)
  );

endmodule
